// File: rtl/reg_wb_arbiter.sv
// Two-requester write-back arbiter feeding the single register-file write port.
// Per-requester FIFOs, round-robin on contention, registered write port, Busy hazard bitmap.
module reg_wb_arbiter #(
    parameter int DEPTH   = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic        Clk_i,
    input  logic        Reset_i,
    input  logic        A_Valid_i,
    output logic        A_Ready_o,
    input  logic [4:0]  A_Addr_i,
    input  logic [31:0] A_Data_i,
    input  logic        B_Valid_i,
    output logic        B_Ready_o,
    input  logic [4:0]  B_Addr_i,
    input  logic [31:0] B_Data_i,
    input  logic        Flush_i,
    output logic        Write_Reg_o,
    output logic [4:0]  W_Addr_o,
    output logic [31:0] W_Data_o,
    output logic [31:0] Busy_o,
    output logic        Idle_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Index 0 is requester A, index 1 is requester B.
    logic [4:0]    addr_q   [2][DEPTH];
    logic [31:0]   data_q   [2][DEPTH];
    logic [AW-1:0] wr_ptr_q [2];
    logic [AW-1:0] wr_ptr_d [2];
    logic [AW-1:0] rd_ptr_q [2];
    logic [AW-1:0] rd_ptr_d [2];
    logic [CW-1:0] cnt_q    [2];
    logic [CW-1:0] cnt_d    [2];
    logic          rr_q, rr_d;   // 0: A favoured on contention, 1: B favoured
    logic          write_reg_q, write_reg_d;
    logic [4:0]    w_addr_q, w_addr_d;
    logic [31:0]   w_data_q, w_data_d;

    logic [1:0]    in_vld;
    logic [4:0]    in_addr  [2];
    logic [31:0]   in_data  [2];
    logic [1:0]    rdy, head_vld, push, pop;
    logic          contested;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;
    logic [31:0]   busy;
    logic [AW-1:0] off;

    always_comb begin
        in_vld     = {B_Valid_i, A_Valid_i};
        in_addr[0] = A_Addr_i;
        in_addr[1] = B_Addr_i;
        in_data[0] = A_Data_i;
        in_data[1] = B_Data_i;
        for (int r = 0; r < 2; r++) begin
            rdy[r]      = cnt_q[r] < CW'(DEPTH);
            head_vld[r] = cnt_q[r] != '0;
            push[r]     = in_vld[r] & rdy[r] & ~Flush_i;
        end
        contested = head_vld[0] & head_vld[1];
        pop[0]    = head_vld[0] & (~head_vld[1] | ~rr_q);
        pop[1]    = head_vld[1] & ~pop[0];
        sel_addr  = pop[1] ? addr_q[1][rd_ptr_q[1]] : addr_q[0][rd_ptr_q[0]];
        sel_data  = pop[1] ? data_q[1][rd_ptr_q[1]] : data_q[0][rd_ptr_q[0]];
    end

    always_comb begin
        rr_d        = rr_q;
        write_reg_d = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        for (int r = 0; r < 2; r++) begin
            wr_ptr_d[r] = wr_ptr_q[r];
            rd_ptr_d[r] = rd_ptr_q[r];
            cnt_d[r]    = cnt_q[r];
        end
        if (Flush_i) begin
            for (int r = 0; r < 2; r++) begin
                wr_ptr_d[r] = '0;
                rd_ptr_d[r] = '0;
                cnt_d[r]    = '0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                wr_ptr_d[r] = wr_ptr_q[r] + AW'(push[r]);
                rd_ptr_d[r] = rd_ptr_q[r] + AW'(pop[r]);
                cnt_d[r]    = cnt_q[r] + CW'(push[r]) - CW'(pop[r]);
            end
            if (contested) begin
                rr_d = ~rr_q;
            end
            // A popped r0 write still consumes its grant but never reaches the port.
            if ((pop != 2'b00) && !(ZERO_R0 && sel_addr == 5'd0)) begin
                write_reg_d = 1'b1;
                w_addr_d    = sel_addr;
                w_data_d    = sel_data;
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (!Reset_i) begin
            for (int r = 0; r < 2; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                cnt_q[r]    <= '0;
            end
            rr_q        <= 1'b0;
            write_reg_q <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                wr_ptr_q[r] <= wr_ptr_d[r];
                rd_ptr_q[r] <= rd_ptr_d[r];
                cnt_q[r]    <= cnt_d[r];
            end
            rr_q        <= rr_d;
            write_reg_q <= write_reg_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
        end
    end

    always_ff @(posedge Clk_i) begin
        for (int r = 0; r < 2; r++) begin
            if (push[r]) begin
                addr_q[r][wr_ptr_q[r]] <= in_addr[r];
                data_q[r][wr_ptr_q[r]] <= in_data[r];
            end
        end
    end

    // Slot i is occupied when its distance from the read pointer is below the count.
    always_comb begin
        busy = '0;
        off  = '0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = AW'(i) - rd_ptr_q[r];
                if ({1'b0, off} < cnt_q[r]) begin
                    busy = busy | (32'd1 << addr_q[r][i]);
                end
            end
        end
        if (ZERO_R0) begin
            busy[0] = 1'b0;
        end
    end

    assign A_Ready_o   = rdy[0];
    assign B_Ready_o   = rdy[1];
    assign Write_Reg_o = write_reg_q;
    assign W_Addr_o    = w_addr_q;
    assign W_Data_o    = w_data_q;
    assign Busy_o      = busy;
    assign Idle_o      = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !write_reg_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: reset, single write, backpressure, contention, r0 drop, flush.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_vld, b_vld, flush;
    logic        a_rdy, b_rdy;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        wr;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] busy;
    logic        idle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.DEPTH(2), .ZERO_R0(1'b1)) dut (
        .Clk_i       (clk),
        .Reset_i     (rst_n),
        .A_Valid_i   (a_vld),
        .A_Ready_o   (a_rdy),
        .A_Addr_i    (a_addr),
        .A_Data_i    (a_data),
        .B_Valid_i   (b_vld),
        .B_Ready_o   (b_rdy),
        .B_Addr_i    (b_addr),
        .B_Data_i    (b_data),
        .Flush_i     (flush),
        .Write_Reg_o (wr),
        .W_Addr_o    (w_addr),
        .W_Data_o    (w_data),
        .Busy_o      (busy),
        .Idle_o      (idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [4:0] ad);
        a_vld  = v;
        a_addr = ad;
        a_data = 32'hA000_0000 | 32'(ad);
    endtask

    task automatic drive_b(input logic v, input logic [4:0] ad);
        b_vld  = v;
        b_addr = ad;
        b_data = 32'hB000_0000 | 32'(ad);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive_a(1'b1, 5'd9);
        drive_b(1'b0, 5'd0);

        // Reset held for two edges with A presenting
        tick();
        tick();
        chk("rst_wr",    32'(wr), 32'd0);
        chk("rst_waddr", 32'(w_addr), 32'd0);
        chk("rst_wdata", w_data, 32'd0);
        chk("rst_busy",  busy, 32'd0);
        chk("rst_idle",  32'(idle), 32'd1);
        rst_n = 1'b1;
        drive_a(1'b0, 5'd0);
        #1;
        chk("rst_ardy", 32'(a_rdy), 32'd1);
        chk("rst_brdy", 32'(b_rdy), 32'd1);

        // Single write: addr 5
        a_vld  = 1'b1;
        a_addr = 5'd5;
        a_data = 32'h1234_5678;
        tick();
        drive_a(1'b0, 5'd0);
        chk("one_busy_c1", busy, 32'h0000_0020);
        chk("one_wr_c1",   32'(wr), 32'd0);
        chk("one_idle_c1", 32'(idle), 32'd0);
        tick();
        chk("one_wr_c2",    32'(wr), 32'd1);
        chk("one_waddr_c2", 32'(w_addr), 32'd5);
        chk("one_wdata_c2", w_data, 32'h1234_5678);
        chk("one_busy_c2",  busy, 32'd0);
        tick();
        chk("one_wr_c3",   32'(wr), 32'd0);
        chk("one_idle_c3", 32'(idle), 32'd1);

        // Backpressure on B while A keeps contending (A favoured first)
        drive_a(1'b1, 5'd20);
        drive_b(1'b1, 5'd10);
        tick();
        drive_a(1'b1, 5'd21);
        drive_b(1'b1, 5'd11);
        tick();
        chk("bp_waddr_e1", 32'(w_addr), 32'd20);
        chk("bp_wr_e1",    32'(wr), 32'd1);
        chk("bp_ardy_e1",  32'(a_rdy), 32'd1);
        chk("bp_brdy_e1",  32'(b_rdy), 32'd0);
        drive_a(1'b1, 5'd22);
        drive_b(1'b1, 5'd12);
        tick();
        chk("bp_waddr_e2", 32'(w_addr), 32'd10);
        chk("bp_ardy_e2",  32'(a_rdy), 32'd0);
        chk("bp_brdy_e2",  32'(b_rdy), 32'd1);
        chk("bp_busy_e2",  busy, 32'h0060_0800);
        drive_a(1'b1, 5'd23);
        tick();
        chk("bp_waddr_e3", 32'(w_addr), 32'd21);
        chk("bp_brdy_e3",  32'(b_rdy), 32'd0);
        chk("bp_ardy_e3",  32'(a_rdy), 32'd1);
        drive_b(1'b0, 5'd0);
        tick();
        chk("bp_waddr_e4", 32'(w_addr), 32'd11);
        drive_a(1'b0, 5'd0);
        tick();
        chk("bp_waddr_e5", 32'(w_addr), 32'd22);
        tick();
        chk("bp_waddr_e6", 32'(w_addr), 32'd12);
        chk("bp_wdata_e6", w_data, 32'hB000_000C);
        tick();
        chk("bp_waddr_e7", 32'(w_addr), 32'd23);
        chk("bp_wdata_e7", w_data, 32'hA000_0017);
        tick();
        chk("bp_wr_e8",   32'(wr), 32'd0);
        chk("bp_idle_e8", 32'(idle), 32'd1);

        // Contention: A 1,2 and B 3,4 on the same edges, A favoured
        drive_a(1'b1, 5'd1);
        drive_b(1'b1, 5'd3);
        tick();
        drive_a(1'b1, 5'd2);
        drive_b(1'b1, 5'd4);
        tick();
        drive_a(1'b0, 5'd0);
        drive_b(1'b0, 5'd0);
        chk("ct_waddr_1", 32'(w_addr), 32'd1);
        chk("ct_brdy",    32'(b_rdy), 32'd0);
        chk("ct_ardy",    32'(a_rdy), 32'd1);
        chk("ct_busy",    busy, 32'h0000_001C);
        tick();
        chk("ct_waddr_2", 32'(w_addr), 32'd3);
        chk("ct_brdy_2",  32'(b_rdy), 32'd1);
        tick();
        chk("ct_waddr_3", 32'(w_addr), 32'd2);
        tick();
        chk("ct_waddr_4", 32'(w_addr), 32'd4);
        chk("ct_wr_4",    32'(wr), 32'd1);
        tick();
        chk("ct_wr_5", 32'(wr), 32'd0);

        // r0 write is consumed silently, then addr 7 issues
        a_vld  = 1'b1;
        a_addr = 5'd0;
        a_data = 32'hFFFF_FFFF;
        tick();
        chk("r0_busy_c1", busy, 32'd0);
        drive_a(1'b1, 5'd7);
        tick();
        drive_a(1'b0, 5'd0);
        chk("r0_wr_c2",   32'(wr), 32'd0);
        chk("r0_busy_c2", busy, 32'h0000_0080);
        tick();
        chk("r0_wr_c3",    32'(wr), 32'd1);
        chk("r0_waddr_c3", 32'(w_addr), 32'd7);
        chk("r0_wdata_c3", w_data, 32'hA000_0007);

        // Flush with both buffers holding entries (B favoured at this point)
        tick();
        drive_a(1'b1, 5'd8);
        drive_b(1'b1, 5'd9);
        tick();
        drive_a(1'b1, 5'd10);
        drive_b(1'b1, 5'd11);
        tick();
        chk("fl_waddr_pre", 32'(w_addr), 32'd9);
        chk("fl_busy_pre",  busy, 32'h0000_0D00);
        flush = 1'b1;
        drive_a(1'b1, 5'd12);
        drive_b(1'b1, 5'd13);
        #1;
        chk("fl_brdy_pre", 32'(b_rdy), 32'd1);
        tick();
        flush = 1'b0;
        drive_a(1'b0, 5'd0);
        drive_b(1'b0, 5'd0);
        chk("fl_busy",  busy, 32'd0);
        chk("fl_wr",    32'(wr), 32'd0);
        chk("fl_idle",  32'(idle), 32'd1);
        chk("fl_ardy",  32'(a_rdy), 32'd1);
        tick();
        chk("fl_wr_2",   32'(wr), 32'd0);
        chk("fl_idle_2", 32'(idle), 32'd1);
        tick();
        chk("fl_wr_3", 32'(wr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
